// File: rtl/pll_phase_stepper.sv
// pll_phase_stepper: dynamic phase-shift controller for the ECP5 EHXPLLL.
// Turns "shift output sel by steps in direction dir" or "reload static phase"
// requests into correctly spaced active-low PHASESTEP/PHASELOADREG pulses.
// Requests are only accepted while a synchronised PLL lock is present, and
// losing lock mid-request aborts it with done+err.
// Ports:
//   clk, rst                 reference clock, synchronous active-high reset
//   pll_locked               PLL LOCK (asynchronous, synchronised here)
//   req/load/sel/dir/steps   request handshake and payload (taken when rdy&req)
//   rdy/busy/done/err        handshake status; done/err are one-cycle pulses
//   phasesel/phasedir        to PLL PHASESEL1:0 / PHASEDIR
//   phasestep/phaseloadreg   to PLL PHASESTEP / PHASELOADREG, active low
module pll_phase_stepper #(
    parameter int unsigned SETUP_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned STEP_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              req,
    input  logic              load,
    input  logic [1:0]        sel,
    input  logic              dir,
    input  logic [STEP_W-1:0] steps,
    output logic              rdy,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        phasesel,
    output logic              phasedir,
    output logic              phasestep,
    output logic              phaseloadreg
);

    localparam int unsigned MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_C  = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE,
        S_ABORT
    } state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               lock_s_q, lock_s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]  rem_q, rem_d;
    logic               load_q, load_d;
    logic [1:0]         sel_q, sel_d;
    logic               dir_q, dir_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               step_q, step_d;
    logic               ldreg_q, ldreg_d;

    // Next state, datapath and outputs; outputs are registered from state_d so
    // they reflect the state entered on the same edge.
    always_comb begin
        state_d  = state_q;
        sync1_d  = pll_locked;
        lock_s_d = sync1_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        load_d   = load_q;
        sel_d    = sel_q;
        dir_d    = dir_q;

        case (state_q)
            S_WAIT_LOCK: begin
                if (lock_s_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                // rdy_q already implies IDLE with lock; a late lock loss is caught in SETUP
                if (rdy_q && req) begin
                    load_d  = load;
                    sel_d   = sel;
                    dir_d   = dir;
                    rem_d   = steps;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end else if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_SETUP: begin
                // First SETUP cycle doubles as the zero-step completion cycle
                if (!lock_s_q) begin
                    state_d = S_ABORT;
                end else if (!load_q && (rem_q == '0)) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(SETUP_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (!lock_s_q) begin
                    state_d = S_ABORT;
                end else if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (!lock_s_q) begin
                    state_d = S_ABORT;
                end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (load_q) begin
                        state_d = S_DONE;
                    end else begin
                        rem_d   = rem_q - STEP_W'(1);
                        state_d = (rem_q == STEP_W'(1)) ? S_DONE : S_PULSE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                rem_d   = '0;
                state_d = S_WAIT_LOCK;
            end
            default: begin
                state_d = S_WAIT_LOCK;
            end
        endcase

        rdy_d   = (state_d == S_IDLE) && lock_s_q;
        busy_d  = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_HOLD) ||
                  (state_d == S_DONE)  || (state_d == S_ABORT);
        done_d  = (state_d == S_DONE) || (state_d == S_ABORT);
        err_d   = (state_d == S_ABORT);
        step_d  = !((state_d == S_PULSE) && !load_d);
        ldreg_d = !((state_d == S_PULSE) && load_d);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_WAIT_LOCK;
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            load_q   <= 1'b0;
            sel_q    <= 2'd0;
            dir_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            step_q   <= 1'b1;
            ldreg_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            lock_s_q <= lock_s_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            load_q   <= load_d;
            sel_q    <= sel_d;
            dir_q    <= dir_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            step_q   <= step_d;
            ldreg_q  <= ldreg_d;
        end
    end

    assign rdy          = rdy_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign phasesel     = sel_q;
    assign phasedir     = dir_q;
    assign phasestep    = step_q;
    assign phaseloadreg = ldreg_q;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Testbench for pll_phase_stepper: accepted requests push their expected
// completion into a queue; a monitor checks pulses and completions.
module tb_pll_phase_stepper;

    localparam int S = 4;
    localparam int P = 4;
    localparam int H = 4;
    localparam int unsigned STEP_W = 8;

    logic              clk = 1'b0;
    logic              rst, pll_locked, req, load, dir;
    logic [1:0]        sel;
    logic [STEP_W-1:0] steps;
    logic              rdy, busy, done, err, phasedir, phasestep, phaseloadreg;
    logic [1:0]        phasesel;

    pll_phase_stepper #(
        .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .req(req), .load(load),
        .sel(sel), .dir(dir), .steps(steps), .rdy(rdy), .busy(busy), .done(done),
        .err(err), .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
        .phaseloadreg(phaseloadreg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       acc;
        int       lat;
        logic [1:0] sel;
        logic     dir;
        int       nstep;
        int       nload;
    } exp_t;

    exp_t q[$];
    exp_t pe, me;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int last_acc = -1;
    int hold_last = -1;
    bit hold_mode = 1'b0;
    int drop_k = -1000;

    int  step_cnt = 0, load_cnt = 0, first_pulse = -1, last_rise = -1;
    int  fall_ps = 0, fall_pl = 0, chk_rdy = 0;
    logic prev_ps = 1'b1, prev_pl = 1'b1;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Completion latency straight from the timing rules
    function automatic int model_lat(input bit l, input int n);
        if (l) return 1 + S + P + H;
        if (n == 0) return 1;
        return 1 + S + n * (P + H);
    endfunction

    // Acceptance happens on the edge where rdy&req; push the expectation
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && rdy && req) begin
            pe.acc   = cyc;
            pe.lat   = model_lat(load, int'(steps));
            pe.sel   = sel;
            pe.dir   = dir;
            pe.nstep = load ? 0 : int'(steps);
            pe.nload = load ? 1 : 0;
            q.push_back(pe);
            acc_cnt++;
            last_acc = cyc;
            if (hold_mode && hold_last >= 0) chk("b2b_gap", cyc - hold_last, 3);
            hold_last = cyc;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_rdy == 1) chk("rdy_after_done", int'(rdy), 1);
            if (chk_rdy == 2) chk("rdy_after_abort", int'(rdy), 0);
            chk_rdy = 0;

            if (prev_ps && !phasestep) begin
                step_cnt++;
                if (first_pulse < 0) first_pulse = cyc;
                if (last_rise >= 0) chk("step_gap", cyc - last_rise, H);
                chk("one_low_step", int'(phaseloadreg), 1);
                fall_ps = cyc;
            end
            if (!prev_ps && phasestep) begin
                chk("step_width", cyc - fall_ps, P);
                last_rise = cyc;
            end
            if (prev_pl && !phaseloadreg) begin
                load_cnt++;
                if (first_pulse < 0) first_pulse = cyc;
                chk("one_low_load", int'(phasestep), 1);
                fall_pl = cyc;
            end
            if (!prev_pl && phaseloadreg) chk("load_width", cyc - fall_pl, P);

            if (busy && q.size() > 0)
                chk("pll_sel_dir_stable", int'({phasesel, phasedir}), int'({q[0].sel, q[0].dir}));
            if (err) chk("err_implies_done", int'(done), 1);

            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done_queue", q.size(), 1);
                end else begin
                    int exp_done, exp_err, ns, nl;
                    me = q.pop_front();
                    exp_done = me.acc + me.lat;
                    exp_err  = 0;
                    ns = me.nstep;
                    nl = me.nload;
                    // Lock drop at edge drop_k is seen by the FSM three edges later
                    if (me.acc <= drop_k + 2 && exp_done >= drop_k + 3) begin
                        exp_done = drop_k + 3;
                        exp_err  = 1;
                        nl = (me.nload == 1 && (me.acc + 1 + S) < exp_done) ? 1 : 0;
                        ns = 0;
                        for (int i = 0; i < me.nstep; i++)
                            if (me.acc + 1 + S + i * (P + H) < exp_done) ns++;
                    end
                    chk("done_cycle", cyc - me.acc, exp_done - me.acc);
                    chk("err", int'(err), exp_err);
                    chk("step_pulses", step_cnt, ns);
                    chk("load_pulses", load_cnt, nl);
                    chk("phasesel", int'(phasesel), int'(me.sel));
                    chk("phasedir", int'(phasedir), int'(me.dir));
                    if (exp_err == 0 && (ns + nl) > 0)
                        chk("first_pulse", first_pulse - me.acc, 1 + S);
                    chk_rdy = (exp_err != 0) ? 2 : 1;
                end
                step_cnt = 0;
                load_cnt = 0;
                first_pulse = -1;
                last_rise = -1;
            end
            prev_ps = phasestep;
            prev_pl = phaseloadreg;
        end
    end

    task automatic issue(input bit l, input int s, input bit d, input int n);
        int c0;
        bit ok;
        @(negedge clk);
        load  = l;
        sel   = 2'(s);
        dir   = d;
        steps = STEP_W'(n);
        req   = 1'b1;
        c0    = acc_cnt;
        ok    = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
        req = 1'b0;
        if (!ok) chk("accept_timeout", acc_cnt - c0, 1);
    endtask

    // Wait for the scoreboard to drain; optionally scramble inputs while busy
    task automatic wait_idle(input int maxc, input bit toggle);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (toggle && busy) begin
                req   = 1'($urandom_range(0, 1));
                load  = 1'($urandom_range(0, 1));
                sel   = 2'($urandom_range(0, 3));
                dir   = 1'($urandom_range(0, 1));
                steps = STEP_W'($urandom_range(0, 255));
            end else begin
                req = 1'b0;
            end
            if (q.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        req = 1'b0;
        if (!ok) chk("idle_timeout", q.size() + int'(busy), 0);
    endtask

    initial begin
        int a;
        rst = 1'b1; pll_locked = 1'b0; req = 1'b0; load = 1'b0;
        sel = 2'd0; dir = 1'b0; steps = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_phasestep", int'(phasestep), 1);
        chk("rst_phaseloadreg", int'(phaseloadreg), 1);
        chk("rst_phasesel", int'(phasesel), 0);
        chk("rst_phasedir", int'(phasedir), 0);
        chk("rst_rdy", int'(rdy), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("unlocked_rdy", int'(rdy), 0);

        // Lock rises: rdy on the 3rd edge
        pll_locked = 1'b1;
        repeat (2) @(negedge clk);
        chk("lock_rdy_edge2", int'(rdy), 0);
        @(negedge clk);
        chk("lock_rdy_edge3", int'(rdy), 1);
        chk("idle_step", int'(phasestep), 1);
        chk("idle_load", int'(phaseloadreg), 1);
        chk("idle_sel", int'(phasesel), 0);

        issue(1'b0, 1, 1'b1, 3);   wait_idle(200, 1'b0);
        issue(1'b1, 2, 1'b0, 0);   wait_idle(200, 1'b0);
        issue(1'b0, 3, 1'b1, 0);   wait_idle(200, 1'b0);

        // req held high with zero-step requests
        @(negedge clk);
        hold_mode = 1'b1; hold_last = -1;
        load = 1'b0; steps = '0; sel = 2'd1; req = 1'b1;
        repeat (14) @(negedge clk);
        req = 1'b0; hold_mode = 1'b0;
        wait_idle(200, 1'b0);

        issue(1'b0, 2, 1'b1, 255); wait_idle(3000, 1'b0);

        // Input scrambling and extra reqs while busy
        issue(1'b0, 1, 1'b0, 4);   wait_idle(200, 1'b1);
        issue(1'b1, 3, 1'b1, 9);   wait_idle(200, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            req   = ($urandom_range(0, 2) == 0);
            load  = ($urandom_range(0, 3) == 0);
            sel   = 2'($urandom_range(0, 3));
            dir   = 1'($urandom_range(0, 1));
            steps = STEP_W'($urandom_range(0, 4));
        end
        @(negedge clk);
        req = 1'b0;
        wait_idle(500, 1'b0);

        // Lock loss during the 2nd pulse of a 5-step request
        issue(1'b0, 3, 1'b0, 5);
        a = last_acc;
        for (int i = 0; i < 40 && cyc < a + 14; i++) begin
            @(posedge clk);
            #1;
        end
        pll_locked = 1'b0;
        drop_k = cyc;
        wait_idle(200, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("unlocked_no_rdy", int'(rdy), 0);
        end
        pll_locked = 1'b1;
        repeat (2) @(negedge clk);
        chk("relock_rdy_edge2", int'(rdy), 0);
        @(negedge clk);
        chk("relock_rdy_edge3", int'(rdy), 1);
        issue(1'b1, 0, 1'b1, 0);   wait_idle(200, 1'b0);
        issue(1'b0, 2, 1'b0, 2);   wait_idle(200, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
